// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker: FSM encoding, default sizing, LFSR taps.
package prbs_checker_pkg;

    // x^4 + x^3 + 1 Fibonacci LFSR defaults
    localparam int unsigned DefWidth   = 4;
    localparam int unsigned DefLockCnt = 8;
    localparam int unsigned DefLossCnt = 3;

    // Predicted bit is sr[TapHi] ^ sr[TapLo]
    localparam int unsigned TapHi = 3;
    localparam int unsigned TapLo = 2;

    localparam int unsigned ErrCntW = 16;

    typedef enum logic [1:0] {
        StSeed   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream input and lock/error status bundle of the PRBS checker.
interface prbs_checker_if;
    import prbs_checker_pkg::*;

    logic               en;
    logic               in;
    logic               clr;
    logic               locked;
    logic               err;
    logic [ErrCntW-1:0] err_cnt;

    modport master (
        output en, in, clr,
        input  locked, err, err_cnt
    );

    modport slave (
        input  en, in, clr,
        output locked, err, err_cnt
    );

endinterface

// File: rtl/prbs_sat_cnt.sv
// 16-bit saturating up-counter with synchronous clear; clear beats increment.
module prbs_sat_cnt
    import prbs_checker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [ErrCntW-1:0] cnt
);

    logic [ErrCntW-1:0] cnt_q;

    // Count up to all-ones and hold there
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds from the stream, self-synchronizes, then checks against
// a free-running reference and counts bit errors while locked.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned LOCK_CNT = DefLockCnt,
    parameter int unsigned LOSS_CNT = DefLossCnt
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);

    localparam int unsigned SeedW  = $clog2(WIDTH);
    localparam int unsigned MatchW = $clog2(LOCK_CNT);
    localparam int unsigned MissW  = $clog2(LOSS_CNT);

    localparam logic [SeedW-1:0]  SeedLast  = SeedW'(WIDTH - 1);
    localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
    localparam logic [MissW-1:0]  MissLast  = MissW'(LOSS_CNT - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [SeedW-1:0]   seed_q, seed_d;
    logic [MatchW-1:0]  match_q, match_d;
    logic [MissW-1:0]   miss_q, miss_d;
    logic               err_q, err_d;

    logic               pred;
    logic [WIDTH-1:0]   sr_shift;

    assign pred     = sr_q[TapHi] ^ sr_q[TapLo];
    assign sr_shift = {sr_q[WIDTH-2:0], bus.in};

    // Next-state: only cycles with en=1 advance anything
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        seed_d  = seed_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                StSeed: begin
                    sr_d = sr_shift;
                    if (seed_q == SeedLast) begin
                        seed_d = '0;
                        // An all-zero seed would lock the LFSR at zero; collect another
                        if (sr_shift != '0) begin
                            state_d = StVerify;
                            match_d = '0;
                        end
                    end else begin
                        seed_d = seed_q + 1'b1;
                    end
                end
                StVerify: begin
                    // Received bits feed the register so it re-synchronizes on its own
                    sr_d    = sr_shift;
                    match_d = (bus.in == pred) ? match_q + 1'b1 : '0;
                    if (sr_shift == '0) begin
                        state_d = StSeed;
                        seed_d  = '0;
                        match_d = '0;
                    end else if ((bus.in == pred) && (match_q == MatchLast)) begin
                        state_d = StLocked;
                        miss_d  = '0;
                    end
                end
                StLocked: begin
                    // Reference runs free so received errors do not corrupt it
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (bus.in != pred) begin
                        err_d = 1'b1;
                        if (miss_q == MissLast) begin
                            state_d = StVerify;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = StSeed;
                end
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSeed;
            sr_q    <= '0;
            seed_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            seed_q  <= seed_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    prbs_sat_cnt u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_d),
        .clr (bus.clr),
        .cnt (bus.err_cnt)
    );

    assign bus.locked = (state_q == StLocked);
    assign bus.err    = err_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed scenarios plus a random stream against a queue model.
module tb_prbs_checker;

    localparam int PSeed   = 0;
    localparam int PVerify = 1;
    localparam int PLocked = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prbs_checker_if bus ();

    prbs_checker #(
        .WIDTH    (4),
        .LOCK_CNT (8),
        .LOSS_CNT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase plus the last four reference bits, oldest first
    int          m_phase;
    int          m_seen;
    int          m_run;
    int          m_miss;
    bit          m_win[$];
    logic [15:0] m_cnt;
    bit          m_err;

    // Golden PRBS history: b[n] = b[n-3] ^ b[n-4], seeded 1,0,1,0
    bit gen[$];

    function automatic bit gen_next();
        bit b;
        int n;
        n = gen.size();
        if (n < 4) b = (n == 0 || n == 2);
        else       b = gen[n-3] ^ gen[n-4];
        gen.push_back(b);
        return b;
    endfunction

    function automatic void model_reset();
        m_phase = PSeed;
        m_seen  = 0;
        m_run   = 0;
        m_miss  = 0;
        m_cnt   = 16'h0000;
        m_err   = 1'b0;
        m_win.delete();
        repeat (4) m_win.push_back(1'b0);
    endfunction

    function automatic void win_shift(bit b);
        m_win.push_back(b);
        void'(m_win.pop_front());
    endfunction

    function automatic int win_ones();
        int ones = 0;
        foreach (m_win[i]) ones += int'(m_win[i]);
        return ones;
    endfunction

    function automatic void model_edge(bit r, bit e, bit b, bit c);
        bit p;
        bit nerr;
        nerr = 1'b0;
        if (r) begin
            model_reset();
            return;
        end
        if (e) begin
            p = m_win[0] ^ m_win[1];
            if (m_phase == PSeed) begin
                win_shift(b);
                m_seen++;
                if (m_seen == 4) begin
                    m_seen = 0;
                    if (win_ones() != 0) begin
                        m_phase = PVerify;
                        m_run   = 0;
                    end
                end
            end else if (m_phase == PVerify) begin
                m_run = (b == p) ? m_run + 1 : 0;
                win_shift(b);
                if (win_ones() == 0) begin
                    m_phase = PSeed;
                    m_seen  = 0;
                    m_run   = 0;
                end else if (m_run == 8) begin
                    m_phase = PLocked;
                    m_miss  = 0;
                end
            end else begin
                win_shift(p);
                if (b != p) begin
                    nerr = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                    m_miss++;
                    if (m_miss == 3) begin
                        m_phase = PVerify;
                        m_run   = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) m_cnt = 16'h0000;
        m_err = nerr;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("locked", {15'b0, bus.locked}, {15'b0, m_phase == PLocked});
        chk("err", {15'b0, bus.err}, {15'b0, m_err});
        chk("err_cnt", bus.err_cnt, m_cnt);
    endtask

    // One clock: drive, let the edge happen, advance the model, sample 1 time unit later
    task automatic cyc(input bit e, input bit b, input bit c);
        bus.en  = e;
        bus.in  = b;
        bus.clr = c;
        @(posedge clk);
        model_edge(rst, e, b, c);
        #1;
        check_model();
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, gen_next(), 1'b0);
    endtask

    task automatic flip();
        bit b;
        b = gen_next();
        cyc(1'b1, ~b, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
    endtask

    logic [15:0] stream31;
    int          vcount;
    bit          e_r, b_r, c_r;

    initial begin
        stream31 = 16'b1010_1111_0001_0011;
        bus.en   = 1'b0;
        bus.in   = 1'b0;
        bus.clr  = 1'b0;
        model_reset();

        // Reset state
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_locked", {15'b0, bus.locked}, 16'd0);
        chk("rst_cnt", bus.err_cnt, 16'd0);
        rst = 1'b0;

        // Reference stream: lock appears right after the 12th bit
        gen.delete();
        for (int i = 0; i < 16; i++) begin
            gen.push_back(stream31[15-i]);
            cyc(1'b1, stream31[15-i], 1'b0);
            if (i == 10) chk("lock_pre12", {15'b0, bus.locked}, 16'd0);
            if (i == 11) chk("lock_at12", {15'b0, bus.locked}, 16'd1);
        end
        chk("s31_cnt", bus.err_cnt, 16'd0);

        // Single flipped bit while locked
        flip();
        chk("one_err", {15'b0, bus.err}, 16'd1);
        chk("one_cnt", bus.err_cnt, 16'd1);
        chk("one_lock", {15'b0, bus.locked}, 16'd1);
        good(6);
        chk("one_after", {15'b0, bus.err}, 16'd0);

        // Three consecutive flips lose lock; 8 good bits relock
        flip();
        flip();
        chk("three_lock2", {15'b0, bus.locked}, 16'd1);
        flip();
        chk("three_lost", {15'b0, bus.locked}, 16'd0);
        chk("three_cnt", bus.err_cnt, 16'd4);
        good(7);
        chk("relock_pre", {15'b0, bus.locked}, 16'd0);
        good(1);
        chk("relock", {15'b0, bus.locked}, 16'd1);

        // All-zero seed never leaves seeding, then a real stream locks after 12 bits
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("zero_lock", {15'b0, bus.locked}, 16'd0);
        gen.delete();
        good(11);
        chk("zero_pre", {15'b0, bus.locked}, 16'd0);
        good(1);
        chk("zero_lock12", {15'b0, bus.locked}, 16'd1);

        // Gapped en: same lock point counted in valid bits
        do_reset();
        gen.delete();
        vcount = 0;
        while (vcount < 12) begin
            cyc(1'b1, gen_next(), 1'b0);
            vcount++;
            if (vcount == 11) chk("gap_pre", {15'b0, bus.locked}, 16'd0);
            if (vcount < 12) cyc(1'b0, 1'b1, 1'b0);
        end
        chk("gap_lock", {15'b0, bus.locked}, 16'd1);
        flip();
        good(2);
        chk("gap_cnt1", bus.err_cnt, 16'd1);
        begin
            bit b;
            b = gen_next();
            cyc(1'b1, ~b, 1'b1);
        end
        chk("clr_err", {15'b0, bus.err}, 16'd1);
        chk("clr_wins", bus.err_cnt, 16'd0);

        // Saturation near the top, then reset while locked
        good(2);
        force dut.u_err_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_err_cnt.cnt_q;
        m_cnt = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            flip();
            good(2);
        end
        chk("sat_cnt", bus.err_cnt, 16'hFFFF);
        chk("sat_lock", {15'b0, bus.locked}, 16'd1);
        rst = 1'b1;
        cyc(1'b1, gen_next(), 1'b0);
        rst = 1'b0;
        chk("rst_mid_lock", {15'b0, bus.locked}, 16'd0);
        chk("rst_mid_cnt", bus.err_cnt, 16'd0);

        // Random stream with sparse errors, gaps, clears and one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) rst = 1'b1;
            e_r = ($urandom_range(3) != 0);
            if (e_r) b_r = gen_next() ^ ($urandom_range(29) == 0);
            else     b_r = 1'($urandom_range(1));
            c_r = ($urandom_range(99) == 0);
            cyc(e_r, b_r, c_r);
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
